ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Behavioural-synthesizable RAM target for the memory controller's RAM-side port.
//  Answers ramREN/ramWEN requests from the memory controller (ramaddr, ramstore).
//  Inserts a programmable wait latency, then reports ramstate = ACCESS.
//  Used as the main-memory model in single-cycle, pipeline and multicore system benches.
// PARAMETERS
//  LAT       2     wait cycles between request acceptance and ACCESS (0..15)
//  DEPTH     1024  number of 32-bit words stored; byte addresses 0 .. 4*DEPTH-1
//  CNT_W     4     width of the latency counter; LAT must satisfy LAT < 2**CNT_W
// PORTS
//  CLK       in   1   system clock, rising edge
//  RST       in   1   asynchronous, active-high reset
//  ramREN    in   1   read request, held until ACCESS is seen
//  ramWEN    in   1   write request, held until ACCESS is seen
//  ramaddr   in   32  byte address; bits [1:0] ignored (word access)
//  ramstore  in   32  write data, sampled at commit edge
//  ramload   out  32  read data; valid only while ramstate == ACCESS
//  ramstate  out  2   ramstate_t {FREE, BUSY, ACCESS, ERROR}
// BEHAVIOUR
//  - Registered state: fsm (IDLE, WAIT, DONE), cnt, lat_addr, lat_wen, rdata_q.
//    RST clears all of these to IDLE / 0. Memory contents are not reset.
//  - req = ramREN | ramWEN. match = req && (ramaddr[31:2] == lat_addr) && (ramWEN == lat_wen).
//  - ramstate is combinational, first true rule wins:
//    1. ERROR  if ramREN & ramWEN, or if word index >= DEPTH.
//    2. FREE   if !req.
//    3. ACCESS if fsm == DONE && match.
//    4. BUSY   otherwise.
//  - ramload = rdata_q when ramstate == ACCESS, else 0.
//  - Reset values: ramstate = FREE, ramload = 0.
//  - FSM transitions:
//    - IDLE: on a valid req (not ERROR), latch addr and op. Go to WAIT with cnt = LAT.
//      If LAT == 0, go directly to DONE and perform the access on that same edge.
//    - WAIT: if !match (request dropped, or address/op changed), restart.
//      Restart means re-latch and reload cnt = LAT, or return to IDLE if !req.
//      If match and cnt == 1, go to DONE and perform the access. Else cnt--.
//    - DONE: stay while match; ACCESS is held and ramload stays stable.
//      On !match, return to IDLE, or restart WAIT directly if a new valid req is present.
//  - Access action on entry to DONE:
//    - Write: mem[idx] <= ramstore, committed exactly once per request.
//    - Read: rdata_q <= mem[idx].
//  - Latency: request first seen in cycle 0; ramstate == ACCESS in cycle LAT+1.
//  - ERROR requests never change memory and never advance the FSM. fsm is forced to IDLE.
//  - Reset mid-WAIT: no write is committed, and the next cycle reports FREE/BUSY per the rules.
//  - Write followed by a read of the same word returns the new data (no forwarding needed).
// STRUCTURE
//  - cpu_types_pkg: reuse word_t and ramstate_t. Add ramfsm_t {RAM_IDLE, RAM_WAIT, RAM_DONE}.
//  - Sub-module ram_word_array: DEPTH x 32 storage, one sync write port, one sync read port.
//    Provides a bench-only backdoor load task. Control/FSM/counter stay in ram_responder.
// TESTING
//  - LAT=2: preload mem[4]=0xDEADBEEF; hold ramREN, ramaddr=0x10.
//    -> BUSY in cycles 0..2; ACCESS with ramload=0xDEADBEEF in cycle 3.
//  - Write 0x12345678 to 0x20, wait for ACCESS, drop; then read 0x20.
//    -> ACCESS returns 0x12345678, and the write was committed exactly once.
//  - LAT=3 read of 0x40; at cycle 1 change ramaddr to 0x44.
//    -> count restarts; ACCESS in cycle 5 with mem[17].
//  - ramREN=ramWEN=1 at 0x8 with ramstore=0xFFFFFFFF -> ERROR every cycle; mem[2] unchanged.
//    DEPTH=1024 with ramaddr=0x1000 -> ERROR.
//  - LAT=0: read of 0x0 -> ACCESS in cycle 1.
//    Hold request 4 cycles -> ACCESS and ramload stable throughout.
//  - LAT=4 write in progress; pulse RST at cycle 2.
//    -> ramstate FREE/BUSY per rules, ramload=0, target word unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: bus word, RAM-port handshake state and the
// RAM responder's internal sequencing states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ramfsm_t;

endpackage

// File: rtl/ram_word_array.sv
// DEPTH x 32-bit word storage with one synchronous write port and one
// synchronous (registered) read port, plus a backdoor preload for benches.
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic          re_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    word_t mem [DEPTH];
    word_t rdata_q;

    // NOTE: the storage array is deliberately not reset (RAM macros cannot be
    // cleared in one cycle), and it uses a plain always so the backdoor task
    // may legally write it too; only the read-data register is reset.
    always @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rdata_q;

    task automatic backdoor_load(input int unsigned idx, input word_t data);
        mem[idx[AW-1:0]] = data;
    endtask

endmodule

// File: rtl/ram_responder.sv
// RAM-side target for the memory controller: accepts ramREN/ramWEN requests,
// waits LAT cycles, performs the word access once and then reports ACCESS.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int unsigned      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
    localparam logic [29:0]      DEPTH_W = 30'(DEPTH);

    logic [29:0]      idx;
    logic             req;
    logic             err;
    logic             match;
    logic             start;
    logic             access;
    logic             mem_we;
    logic             mem_re;
    word_t            rdata;
    ramstate_t        state;

    ramfsm_t          fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      lat_addr_q, lat_addr_d;
    logic             lat_wen_q, lat_wen_d;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^ramaddr[1:0];

    assign idx   = ramaddr[31:2];
    assign req   = ramREN | ramWEN;
    assign err   = (ramREN & ramWEN) | (idx >= DEPTH_W);
    assign match = req && (idx == lat_addr_q) && (ramWEN == lat_wen_q);

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        lat_wen_d  = lat_wen_q;
        start      = 1'b0;
        access     = 1'b0;

        if (err) begin
            fsm_d = RAM_IDLE;
        end else begin
            unique case (fsm_q)
                RAM_IDLE: start = req;
                RAM_WAIT: begin
                    if (!match) begin
                        start = req;
                        if (!req) fsm_d = RAM_IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        fsm_d  = RAM_DONE;
                        access = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RAM_DONE: begin
                    if (!match) begin
                        start = req;
                        if (!req) fsm_d = RAM_IDLE;
                    end
                end
                default: fsm_d = RAM_IDLE;
            endcase

            // A new request (fresh or replacing a changed one) restarts the wait.
            if (start) begin
                lat_addr_d = idx;
                lat_wen_d  = ramWEN;
                if (LAT == 0) begin
                    fsm_d  = RAM_DONE;
                    access = 1'b1;
                end else begin
                    fsm_d = RAM_WAIT;
                    cnt_d = LAT_CNT;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm_q      <= RAM_IDLE;
            cnt_q      <= '0;
            lat_addr_q <= '0;
            lat_wen_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_wen_q  <= lat_wen_d;
        end
    end

    assign mem_we = access & ramWEN;
    assign mem_re = access & ~ramWEN;

    ram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i     (CLK),
        .rst_i     (RST),
        .we_i      (mem_we),
        .wr_addr_i (idx[AW-1:0]),
        .wr_data_i (ramstore),
        .re_i      (mem_re),
        .rd_addr_i (idx[AW-1:0]),
        .rd_data_o (rdata)
    );

    always_comb begin
        if (err)                                state = ERROR;
        else if (!req)                          state = FREE;
        else if ((fsm_q == RAM_DONE) && match)  state = ACCESS;
        else                                    state = BUSY;
    end

    assign ramstate = state;
    assign ramload  = (state == ACCESS) ? rdata : '0;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT = 2, 3, 0 and 4 with a per-cycle
// expectation queue drained by an independent monitor on the falling edge.
module tb_ram_responder;
    import cpu_types_pkg::*;

    typedef struct {
        int          inst;
        logic        is_wr;
        logic [1:0]  st;
        logic        chk_load;
        logic [31:0] ld;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ren   [4];
    logic        wen   [4];
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [31:0] ld_w  [4];
    logic [1:0]  st_w  [4];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_cnt0 = 0;
    int   wr_cnt3 = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ram_responder #(
            .LAT   ((g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 0 : 4),
            .DEPTH (1024),
            .CNT_W (4)
        ) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .ramREN   (ren[g]),
            .ramWEN   (wen[g]),
            .ramaddr  (addr[g]),
            .ramstore (wdata[g]),
            .ramload  (ld_w[g]),
            .ramstate (st_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (g_dut[0].u_dut.mem_we) wr_cnt0 = wr_cnt0 + 1;
        if (g_dut[3].u_dut.mem_we) wr_cnt3 = wr_cnt3 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_wr) begin
                check(e.name, (e.inst == 0) ? wr_cnt0 : wr_cnt3, e.ld);
            end else begin
                check({e.name, "_state"}, {30'd0, st_w[e.inst]}, {30'd0, e.st});
                if (e.chk_load) check({e.name, "_load"}, ld_w[e.inst], e.ld);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        ren[i]   = r;
        wen[i]   = w;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic expect_st(input int i, input logic [1:0] st, input logic cl,
                             input logic [31:0] ld, input string nm);
        exp_t e;
        e.inst = i; e.is_wr = 1'b0; e.st = st; e.chk_load = cl; e.ld = ld; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_wr(input int i, input int cnt, input string nm);
        exp_t e;
        e.inst = i; e.is_wr = 1'b1; e.st = 2'd0; e.chk_load = 1'b0; e.ld = cnt; e.name = nm;
        sb.push_back(e);
    endtask

    // Hold the current inputs for n cycles, expecting the same response each cycle.
    task automatic hold(input int i, input int n, input logic [1:0] st, input logic cl,
                        input logic [31:0] ld, input string nm);
        for (int k = 0; k < n; k++) begin
            expect_st(i, st, cl, ld, nm);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) expect_st(i, FREE, 1'b1, 32'h0, "reset");
        step();
        rst = 1'b0;

        g_dut[0].u_dut.u_mem.backdoor_load(4, 32'hDEADBEEF);
        g_dut[0].u_dut.u_mem.backdoor_load(2, 32'h22222222);
        g_dut[0].u_dut.u_mem.backdoor_load(1023, 32'h3FF003FF);
        g_dut[1].u_dut.u_mem.backdoor_load(16, 32'hAAAA0016);
        g_dut[1].u_dut.u_mem.backdoor_load(17, 32'h55550017);
        g_dut[2].u_dut.u_mem.backdoor_load(0, 32'h0BADF00D);
        g_dut[3].u_dut.u_mem.backdoor_load(8, 32'hCAFE0008);
        step();

        // LAT=2 read of 0x10: BUSY cycles 0..2, ACCESS in cycle 3.
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        hold(0, 3, BUSY, 1'b1, 32'h0, "lat2_rd_busy");
        hold(0, 1, ACCESS, 1'b1, 32'hDEADBEEF, "lat2_rd_access");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "lat2_rd_free");

        // Write 0x12345678 to 0x20, hold ACCESS two cycles, then read it back.
        drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        hold(0, 3, BUSY, 1'b0, 32'h0, "wr_busy");
        hold(0, 2, ACCESS, 1'b0, 32'h0, "wr_access");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "wr_free");
        expect_wr(0, 1, "wr_once");
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        hold(0, 3, BUSY, 1'b1, 32'h0, "rbw_busy");
        hold(0, 1, ACCESS, 1'b1, 32'h12345678, "rbw_access");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "rbw_free");

        // LAT=3 read of 0x40, address moves to 0x44 in cycle 1: ACCESS in cycle 5.
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        hold(1, 1, BUSY, 1'b1, 32'h0, "restart_c0");
        drive(1, 1'b1, 1'b0, 32'h44, 32'h0);
        hold(1, 4, BUSY, 1'b1, 32'h0, "restart_busy");
        hold(1, 1, ACCESS, 1'b1, 32'h55550017, "restart_access");
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(1, 1, FREE, 1'b1, 32'h0, "restart_free");

        // Simultaneous read+write is an error and must not touch mem[2].
        drive(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
        hold(0, 4, ERROR, 1'b1, 32'h0, "both_err");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "both_free");
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
        hold(0, 3, BUSY, 1'b1, 32'h0, "err_rd_busy");
        hold(0, 1, ACCESS, 1'b1, 32'h22222222, "err_rd_unchanged");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "err_rd_free");
        expect_wr(0, 1, "err_no_write");

        // Out-of-range word index errors; the last valid word is served normally.
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        hold(0, 2, ERROR, 1'b1, 32'h0, "range_err");
        drive(0, 1'b1, 1'b0, 32'hFFC, 32'h0);
        hold(0, 3, BUSY, 1'b1, 32'h0, "top_word_busy");
        hold(0, 1, ACCESS, 1'b1, 32'h3FF003FF, "top_word_access");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(0, 1, FREE, 1'b1, 32'h0, "top_word_free");

        // LAT=0 read of 0x0: ACCESS from cycle 1, stable for the whole hold.
        drive(2, 1'b1, 1'b0, 32'h0, 32'h0);
        hold(2, 1, BUSY, 1'b1, 32'h0, "lat0_busy");
        hold(2, 4, ACCESS, 1'b1, 32'h0BADF00D, "lat0_access");
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(2, 1, FREE, 1'b1, 32'h0, "lat0_free");

        // LAT=4 write to 0x20 interrupted by reset in cycle 2: nothing committed.
        drive(3, 1'b0, 1'b1, 32'h20, 32'h99999999);
        hold(3, 2, BUSY, 1'b1, 32'h0, "rstw_busy");
        rst = 1'b1;
        hold(3, 1, BUSY, 1'b1, 32'h0, "rstw_in_reset");
        rst = 1'b0;
        hold(3, 1, BUSY, 1'b1, 32'h0, "rstw_after_reset");
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(3, 1, FREE, 1'b1, 32'h0, "rstw_free");
        expect_wr(3, 0, "rstw_no_write");
        drive(3, 1'b1, 1'b0, 32'h20, 32'h0);
        hold(3, 5, BUSY, 1'b1, 32'h0, "rstw_rd_busy");
        hold(3, 1, ACCESS, 1'b1, 32'hCAFE0008, "rstw_rd_unchanged");
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        hold(3, 1, FREE, 1'b1, 32'h0, "rstw_rd_free");

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
